// File: rtl/axi_rd_arbiter_if.sv
// AXI read-channel bundle (AR + R) used for the requester ports and the shared master port.
interface axi_rd_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4
);
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic [3:0]        arqos;
  logic [3:0]        arregion;
  logic              rvalid;
  logic              rready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;

  // Master issues AR and accepts R; lock/cache/prot/qos/region only exist on the master side.
  modport master (
    output arvalid, arid, araddr, arlen, arsize, arburst,
    output arlock, arcache, arprot, arqos, arregion, rready,
    input  arready, rvalid, rid, rdata, rresp, rlast
  );

  modport slave (
    input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
    output arready, rvalid, rid, rdata, rresp, rlast
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// 2:1 AXI read arbiter (port 0 = fetch, port 1 = load/store), one transaction outstanding.
// Define AXI_RD_ARB_RR_EN for round-robin; otherwise port 1 has fixed priority.
module axi_rd_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  axi_rd_arbiter_if.slave  s0,
  axi_rd_arbiter_if.slave  s1,
  axi_rd_arbiter_if.master m,
  output logic             busy,
  output logic [1:0]       grant
);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [ID_W-1:0]   arid_q, arid_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [7:0]        arlen_q, arlen_d;
  logic [2:0]        arsize_q, arsize_d;
  logic [1:0]        arburst_q, arburst_d;
  logic [1:0]        req;
  logic [1:0]        win;
`ifdef AXI_RD_ARB_RR_EN
  logic              rr_ptr_q, rr_ptr_d;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= 2'b00;
      arid_q    <= '0;
      araddr_q  <= '0;
      arlen_q   <= 8'd0;
      arsize_q  <= 3'd0;
      arburst_q <= 2'd0;
`ifdef AXI_RD_ARB_RR_EN
      rr_ptr_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      arid_q    <= arid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arsize_q  <= arsize_d;
      arburst_q <= arburst_d;
`ifdef AXI_RD_ARB_RR_EN
      rr_ptr_q  <= rr_ptr_d;
`endif
    end
  end

  // Next-state, winner selection and AR payload capture
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    arid_d    = arid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;
    arburst_d = arburst_q;
    req       = {s1.arvalid, s0.arvalid};
`ifdef AXI_RD_ARB_RR_EN
    rr_ptr_d  = rr_ptr_q;
    // On contention the port that was not granted last wins.
    if (req == 2'b11) win = rr_ptr_q ? 2'b01 : 2'b10;
    else              win = req;
`else
    win = s1.arvalid ? 2'b10 : {1'b0, s0.arvalid};
`endif

    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = ADDR;
          grant_d = win;
          if (win[1]) begin
            arid_d    = s1.arid;
            araddr_d  = s1.araddr;
            arlen_d   = s1.arlen;
            arsize_d  = s1.arsize;
            arburst_d = s1.arburst;
          end else begin
            arid_d    = s0.arid;
            araddr_d  = s0.araddr;
            arlen_d   = s0.arlen;
            arsize_d  = s0.arsize;
            arburst_d = s0.arburst;
          end
`ifdef AXI_RD_ARB_RR_EN
          rr_ptr_d = win[1];
`endif
        end
      end
      ADDR: begin
        if (m.arready) state_d = DATA;
      end
      DATA: begin
        if (m.rvalid && m.rready && m.rlast) begin
          state_d = IDLE;
          grant_d = 2'b00;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // Outputs: AR from registers, R routed combinationally to the owner
  always_comb begin
    busy        = (state_q != IDLE);
    grant       = grant_q;
    m.arvalid   = 1'b0;
    m.arid      = arid_q;
    m.araddr    = araddr_q;
    m.arlen     = arlen_q;
    m.arsize    = arsize_q;
    m.arburst   = arburst_q;
    m.arlock    = 1'b0;
    m.arcache   = 4'd0;
    m.arprot    = 3'd0;
    m.arqos     = 4'd0;
    m.arregion  = 4'd0;
    m.rready    = 1'b0;
    s0.arready  = 1'b0;
    s0.rvalid   = 1'b0;
    s0.rid      = ID_W'(0);
    s0.rdata    = DATA_W'(0);
    s0.rresp    = 2'b00;
    s0.rlast    = 1'b0;
    s1.arready  = 1'b0;
    s1.rvalid   = 1'b0;
    s1.rid      = ID_W'(0);
    s1.rdata    = DATA_W'(0);
    s1.rresp    = 2'b00;
    s1.rlast    = 1'b0;

    if (state_q == ADDR) begin
      m.arvalid  = 1'b1;
      s0.arready = grant_q[0] & m.arready;
      s1.arready = grant_q[1] & m.arready;
    end

    if (state_q == DATA) begin
      if (grant_q[0]) begin
        s0.rvalid = m.rvalid;
        s0.rid    = m.rid;
        s0.rdata  = m.rdata;
        s0.rresp  = m.rresp;
        s0.rlast  = m.rlast;
        m.rready  = s0.rready;
      end else if (grant_q[1]) begin
        s1.rvalid = m.rvalid;
        s1.rid    = m.rid;
        s1.rdata  = m.rdata;
        s1.rresp  = m.rresp;
        s1.rlast  = m.rlast;
        m.rready  = s1.rready;
      end
    end
  end

endmodule
